dmem_sbuf: RTL and testbench
============================

DMEM_SBUF -- requirements
Module: dmem_sbuf

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 64, meaning data-memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port MemWrite  input  1  store request from the datapath this cycle.
REQ-006 SHALL have port MemRead  input  1  load request from the datapath this cycle.
REQ-007 SHALL have port ALUout  input  32  byte address of the access.
REQ-008 SHALL have port writedata  input  32  store data.
REQ-009 SHALL have port readdata  output  32  registered load data.
REQ-010 SHALL have port stall  output  1  combinational: the current store is not accepted, and the datapath holds its inputs.
REQ-011 SHALL have port fault  output  1  registered one-cycle pulse flagging an illegal access.
REQ-012 SHALL have port sb_count  output  clog2(SB_DEPTH)+1  current store-buffer occupancy.

Function
REQ-013 SHALL index memory with word index ALUout[clog2(MEM_WORDS)+1:2]; higher address bits are ignored (aliasing).
REQ-014 SHALL classify an access as legal only when ALUout[1:0]==0 and exactly one of MemRead/MemWrite is 1.
- Illegal cases: misaligned address, or both requests set.
REQ-015 SHALL, for an illegal access, perform no read, no store, and no buffer change, and set fault=1 for the next cycle only.
REQ-016 SHALL buffer each legal, accepted store as {index, writedata} at the FIFO tail; the store latency to the buffer is one edge.
REQ-017 SHALL drive stall=1 exactly when MemWrite=1, the access is legal, and sb_count==SB_DEPTH; otherwise stall=0.
REQ-018 SHALL drain the oldest buffer entry into memory on a cycle when sb_count>0 and either:
- MemRead=0 and MemWrite=0, or
- stall=1.
REQ-019 SHALL NOT drain on any cycle with a legal accepted store, a legal load, or an illegal access.
REQ-020 SHALL accept a stalled store on the first cycle stall deasserts; a stall lasts exactly one cycle under REQ-018.
REQ-021 SHALL serve a legal load with one-cycle latency: readdata updates on the edge after the MemRead cycle.
REQ-022 SHALL forward load data from the youngest buffer entry whose index matches; otherwise from memory.
REQ-023 SHALL hold readdata unchanged on cycles without a legal load.
REQ-024 SHALL make a store accepted in cycle N visible to a load in cycle N+1 or later, through forwarding or memory.
REQ-025 SHALL wrap head/tail pointers modulo SB_DEPTH; sb_count SHALL never exceed SB_DEPTH or underflow below 0.
REQ-026 SHALL drain buffer entries to memory in acceptance order; two pending stores to the same index leave the later data in memory.

Reset
REQ-027 SHALL, while reset=1 and independent of clk, force readdata=0, fault=0, sb_count=0, and both pointers to 0.
REQ-028 SHALL discard pending buffer entries on reset; memory array contents are not reset.
REQ-029 SHALL ignore MemRead/MemWrite while reset=1; reset asserted mid-stall clears stall on the next evaluation because sb_count=0.

Verification
REQ-030 Store 0xDEADBEEF to 0x10, then load 0x10 the next cycle -> readdata=0xDEADBEEF one cycle later via forwarding, sb_count=1.
REQ-031 Stores to 0x0, 0x4, 0x8, 0xC, 0x10 on consecutive cycles -> stall=1 only in the 5th cycle with sb_count=4; the 5th store is accepted the following cycle; 0x0 is drained first.
REQ-032 Stores 0x11 then 0x22 to 0x20, then idle until sb_count=0, then load 0x20 -> readdata=0x22.
REQ-033 Store to 0x13; a separate cycle with MemRead=MemWrite=1 at 0x40 -> fault pulses one cycle after each; sb_count and readdata unchanged.
REQ-034 Fill the buffer to 3, assert reset asynchronously between edges -> sb_count=0, readdata=0 immediately; a later load of those addresses returns pre-store memory contents.
REQ-035 Store 0xA5A5A5A5 to 0x100 (aliases index 0 with MEM_WORDS=64), drain, load 0x0 -> readdata=0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_sbuf.sv
// Data memory with a small in-order store buffer.
// Stores are queued and retire to memory on idle or stalled cycles.
// Loads see the youngest matching buffered store, otherwise memory.
module dmem_sbuf #(
  parameter int MEM_WORDS = 64,
  parameter int SB_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic [31:0]               ALUout,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  output logic                      stall,
  output logic                      fault,
  output logic [$clog2(SB_DEPTH):0] sb_count
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [31:0]   data;
  } sb_ent_t;

  sb_ent_t       sb  [SB_DEPTH];
  logic [31:0]   mem [MEM_WORDS];
  logic [PW-1:0] head, tail;

  logic [IW-1:0] idx;
  logic          req, legal, full, st_acc, ld, drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic          unused_addr;

  // Upper address bits alias onto the same word.
  assign idx         = ALUout[IW+1:2];
  assign unused_addr = ^ALUout[31:IW+2];

  assign req    = MemWrite | MemRead;
  assign legal  = (ALUout[1:0] == 2'b00) && (MemWrite ^ MemRead);
  assign full   = (sb_count == CW'(SB_DEPTH));
  assign stall  = MemWrite && legal && full;
  assign st_acc = MemWrite && legal && !full;
  assign ld     = MemRead && legal;
  // Retire only when the datapath leaves the memory alone, or while a store waits for room.
  assign drain  = (sb_count != '0) && (!req || stall);

  // Walk from oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] pos;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    pos      = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      pos = head + PW'(k);
      if ((CW'(k) < sb_count) && (sb[pos].idx == idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb[pos].data;
      end
    end
  end

  // Control state, load data and fault pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      fault    <= 1'b0;
      sb_count <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      fault <= req && !legal;
      if (ld)
        readdata <= fwd_hit ? fwd_data : mem[idx];
      if (st_acc) begin
        tail     <= tail + 1'b1;
        sb_count <= sb_count + 1'b1;
      end else if (drain) begin
        head     <= head + 1'b1;
        sb_count <= sb_count - 1'b1;
      end
    end
  end

  // Buffer payload; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (st_acc && !reset)
      sb[tail] <= '{idx: idx, data: writedata};
  end

  // Memory array is not reset; it only changes when the oldest entry retires.
  always_ff @(posedge clk) begin
    if (drain && !reset)
      mem[sb[head].idx] <= sb[head].data;
  end
endmodule

// File: tb/tb_dmem_sbuf.sv
// Bench for dmem_sbuf: directed scenarios then random traffic, checked
// against a queue-based model of the store buffer and memory.
module tb_dmem_sbuf;
  localparam int MEM_WORDS = 64;
  localparam int SB_DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite, MemRead;
  logic [31:0] ALUout, writedata;
  logic [31:0] readdata;
  logic        stall, fault;
  logic [$clog2(SB_DEPTH):0] sb_count;

  dmem_sbuf #(.MEM_WORDS(MEM_WORDS), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .ALUout(ALUout), .writedata(writedata), .readdata(readdata),
    .stall(stall), .fault(fault), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] d;
  } ent_t;

  ent_t        sbq[$];
  logic [31:0] mmem [MEM_WORDS];
  logic [31:0] m_rd;
  logic        m_fault;
  logic        last_stall;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One datapath cycle; entered and left at a falling edge.
  task automatic step(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] wd);
    logic legal, req, es;
    int   ix;
    MemWrite = mw; MemRead = mr; ALUout = a; writedata = wd;
    #1;
    ix    = int'((a >> 2) % MEM_WORDS);
    legal = (a[1:0] == 2'b00) && (mw != mr);
    req   = mw | mr;
    es    = mw && legal && (sbq.size() == SB_DEPTH);
    chk("stall", {31'b0, stall}, {31'b0, es});
    m_fault = req && !legal;
    if (legal && mr) begin
      m_rd = mmem[ix];
      foreach (sbq[k]) if (sbq[k].idx == ix) m_rd = sbq[k].d;
    end
    if (legal && mw && !es) sbq.push_back('{ix, wd});
    else if (sbq.size() > 0 && (!req || es)) begin
      mmem[sbq[0].idx] = sbq[0].d;
      void'(sbq.pop_front());
    end
    last_stall = es;
    @(posedge clk); #1;
    chk("readdata", readdata, m_rd);
    chk("fault", {31'b0, fault}, {31'b0, m_fault});
    chk("sb_count", 32'(sb_count), 32'(sbq.size()));
    @(negedge clk);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d);
    for (int i = 0; i < 4 && last_stall; i++) step(1'b1, 1'b0, a, d);
  endtask

  task automatic drain_all();
    for (int i = 0; i < SB_DEPTH + 2 && sbq.size() > 0; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        mw, mr;
    logic [31:0] a, d;
    int          op;
    MemWrite = 0; MemRead = 0; ALUout = 0; writedata = 0;
    m_rd = 0; m_fault = 0; last_stall = 0;

    // Reset acts without a clock edge.
    #1 reset = 1'b1;
    #2;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_sb_count", 32'(sb_count), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Give every memory word a known value.
    for (int i = 0; i < MEM_WORDS; i++) begin
      store(32'(i * 4), $urandom);
      drain_all();
    end

    // Store then immediate load forwards from the buffer.
    step(1, 0, 32'h10, 32'hDEADBEEF);
    step(0, 1, 32'h10, 32'h0);
    chk("fwd_data", readdata, 32'hDEADBEEF);
    chk("fwd_count", 32'(sb_count), 32'd1);
    drain_all();

    // Fill the buffer; the fifth store stalls once, then is accepted.
    step(1, 0, 32'h00, 32'h1000);
    step(1, 0, 32'h04, 32'h1004);
    step(1, 0, 32'h08, 32'h1008);
    step(1, 0, 32'h0C, 32'h100C);
    chk("full_count", 32'(sb_count), 32'd4);
    step(1, 0, 32'h10, 32'h1010);
    chk("full_stall", {31'b0, last_stall}, 32'd1);
    step(1, 0, 32'h10, 32'h1010);
    chk("full_accept_count", 32'(sb_count), 32'd4);
    chk("oldest_drained", mmem[0], 32'h1000);
    step(0, 1, 32'h00, 32'h0);
    chk("oldest_load", readdata, 32'h1000);
    drain_all();

    // Two stores to one word: later data survives the drain.
    step(1, 0, 32'h20, 32'h11);
    step(1, 0, 32'h20, 32'h22);
    drain_all();
    step(0, 1, 32'h20, 32'h0);
    chk("same_idx", readdata, 32'h22);

    // Illegal accesses pulse fault and change nothing.
    step(1, 0, 32'h13, 32'h5555);
    chk("fault_misalign", {31'b0, fault}, 32'd1);
    step(0, 0, 32'h0, 32'h0);
    chk("fault_clear", {31'b0, fault}, 32'd0);
    step(1, 1, 32'h40, 32'h6666);
    chk("fault_both", {31'b0, fault}, 32'd1);
    chk("fault_rd_hold", readdata, 32'h22);

    // Mid-cycle reset discards buffered stores.
    step(0, 1, 32'h30, 32'h0);
    step(1, 0, 32'h30, 32'hAAAA0001);
    step(1, 0, 32'h34, 32'hAAAA0002);
    step(1, 0, 32'h38, 32'hAAAA0003);
    chk("pre_rst_count", 32'(sb_count), 32'd3);
    MemWrite = 0; MemRead = 0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(sb_count), 32'h0);
    chk("async_rst_rd", readdata, 32'h0);
    sbq.delete(); m_rd = 0; m_fault = 0;
    @(negedge clk); reset = 1'b0;
    step(0, 1, 32'h30, 32'h0);
    step(0, 1, 32'h34, 32'h0);
    step(0, 1, 32'h38, 32'h0);

    // Upper address bits alias.
    store(32'h100, 32'hA5A5A5A5);
    drain_all();
    step(0, 1, 32'h0, 32'h0);
    chk("alias", readdata, 32'hA5A5A5A5);

    // Random traffic over a few words so forwarding and aliasing collide.
    mw = 0; mr = 0; a = 0; d = 0;
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        op = $urandom_range(0, 9);
        a  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
        d  = $urandom;
        mw = (op <= 3);
        mr = (op >= 4 && op <= 6);
        if (op == 9) begin
          if ($urandom_range(0, 1) == 1) begin mw = 1; mr = 1; end
          else begin mw = 1'($urandom_range(0, 1)); mr = !mw; a[1:0] = 2'($urandom_range(1, 3)); end
        end
      end
      step(mw, mr, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
